clkdiv_bank: RTL and testbench

CLKDIV_BANK -- requirements
Module: clkdiv_bank

---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/clkdiv_chan.sv | 69 ++++++
 rtl/clkdiv_bank.sv | 89 ++++++++
 tb/tb_clkdiv_bank.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider bank: channel limit and FSM states.
package clkdiv_pkg;

  // Largest number of divided-clock channels a bank may be built with.
  localparam int MAX_CH = 8;

  // Bring-up sequence: wait for PLL lock, let it settle, then run the dividers.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: phase counter, pending/active ratio and registered
// enable-pulse / square-wave outputs. Ratio 0 behaves as ratio 1.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_now,   // bank is in RUN this cycle
  input  logic             run_next,  // bank will be in RUN next cycle
  input  logic             resync,    // realign request, already qualified with RUN
  input  logic             load,
  input  logic [DIV_W-1:0] ratio,
  output logic             clk_en,
  output logic             clk_div
);

  localparam logic [DIV_W-1:0] DEF_R  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE    = 1;
  localparam logic [DIV_W:0]   ONE_X  = 1;

  logic [DIV_W-1:0] pending_q, pending_n;
  logic [DIV_W-1:0] active_q, active_n;
  logic [DIV_W-1:0] cnt_q, cnt_n;
  logic [DIV_W-1:0] r_cur, r_next;
  logic [DIV_W:0]   half_next;
  logic             wrap, apply;
  logic             en_n, div_n;

  // Next ratio/counter values; outputs are derived from the next-cycle
  // counter so the registered pulse lines up with cnt==0.
  always_comb begin
    pending_n = load ? ratio : pending_q;
    r_cur     = (active_q == '0) ? ONE : active_q;
    wrap      = run_now && (cnt_q == (r_cur - ONE));
    // Outside RUN the newest ratio takes effect at once; in RUN only at a
    // period boundary (wrap) or on a realign, never mid-period.
    apply     = !run_now || wrap || resync;
    active_n  = apply ? pending_n : active_q;
    r_next    = (active_n == '0) ? ONE : active_n;
    half_next = ({1'b0, r_next} + ONE_X) >> 1;
    cnt_n     = '0;
    if (run_next && run_now && !resync && !wrap) begin
      cnt_n = cnt_q + ONE;
    end
    en_n  = run_next && (cnt_n == '0);
    div_n = run_next && ({1'b0, cnt_n} < half_next);
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= DEF_R;
      active_q  <= DEF_R;
      cnt_q     <= '0;
      clk_en    <= 1'b0;
      clk_div   <= 1'b0;
    end else begin
      pending_q <= pending_n;
      active_q  <= active_n;
      cnt_q     <= cnt_n;
      clk_en    <= en_n;
      clk_div   <= div_n;
    end
  end

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NUM_CH programmable clock-enable dividers gated by a PLL-lock
// bring-up FSM. All channels start phase-aligned on the first RUN cycle.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 8,
  parameter int DEF_DIV   = 2,
  parameter int LOCK_WAIT = 64
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic                    pll_lock,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    resync,
  output logic                    ready,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       clk_div
);

  localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = 1;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("clkdiv_bank: NUM_CH out of range");
  end

  state_e        state_q, state_n;
  logic [SW-1:0] settle_q, settle_n;
  logic          run_now, run_next, resync_run;

  // Next-state logic: any cycle with pll_lock low sends the bank back to
  // WAIT_LOCK; SETTLE counts consecutive locked cycles before RUN.
  always_comb begin
    state_n  = state_q;
    settle_n = '0;
    case (state_q)
      ST_WAIT_LOCK: if (pll_lock) state_n = ST_SETTLE;
      ST_SETTLE: begin
        if (!pll_lock) begin
          state_n = ST_WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_n = ST_RUN;
        end else begin
          settle_n = settle_q + SETTLE_ONE;
        end
      end
      ST_RUN:       if (!pll_lock) state_n = ST_WAIT_LOCK;
      default:      state_n = ST_WAIT_LOCK;
    endcase
  end

  // FSM state, settle counter and registered ready.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q  <= ST_WAIT_LOCK;
      settle_q <= '0;
      ready    <= 1'b0;
    end else begin
      state_q  <= state_n;
      settle_q <= settle_n;
      ready    <= (state_n == ST_RUN);
    end
  end

  assign run_now    = (state_q == ST_RUN);
  assign run_next   = (state_n == ST_RUN);
  assign resync_run = resync && run_now;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clkdiv_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk     (clkin),
      .rst     (reset),
      .run_now (run_now),
      .run_next(run_next),
      .resync  (resync_run),
      .load    (div_load[g]),
      .ratio   (div_ratio[g*DIV_W +: DIV_W]),
      .clk_en  (clk_en[g]),
      .clk_div (clk_div[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Bench for clkdiv_bank: directed bring-up / ratio / resync / lock-loss /
// reset steps plus a randomized stretch, all checked every cycle against a
// timestamp-based reference model (period start cycle + period length).
module tb_clkdiv_bank;

  localparam int NUM_CH    = 2;
  localparam int DIV_W     = 8;
  localparam int DEF_DIV   = 2;
  localparam int LOCK_WAIT = 64;
  localparam int W         = 1 + 2 * NUM_CH;

  logic                    clkin = 1'b0;
  logic                    reset = 1'b0;
  logic                    pll_lock = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_ratio = '0;
  logic [NUM_CH-1:0]       div_load = '0;
  logic                    resync = 1'b0;
  logic                    ready;
  logic [NUM_CH-1:0]       clk_en;
  logic [NUM_CH-1:0]       clk_div;

  clkdiv_bank #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .DEF_DIV  (DEF_DIV),
    .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .pll_lock (pll_lock),
    .div_ratio(div_ratio),
    .div_load (div_load),
    .resync   (resync),
    .ready    (ready),
    .clk_en   (clk_en),
    .clk_div  (clk_div)
  );

  // Clock and watchdog.
  always #5 clkin = ~clkin;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard state.
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: run follows the length of the current pll_lock-high
  // streak; each channel remembers when its current period began and how
  // long that period is.
  int streak;
  bit m_run;
  int pend [NUM_CH];
  int s_cyc[NUM_CH];
  int len  [NUM_CH];

  function automatic int eff(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic model_reset();
    streak = 0;
    m_run  = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pend[ch]  = DEF_DIV;
      s_cyc[ch] = 0;
      len[ch]   = DEF_DIV;
    end
    exp_q.delete();
  endtask

  // Called right at the edge, using the inputs held during the cycle before.
  task automatic model_step();
    bit run_prev;
    logic [NUM_CH-1:0] en_v, div_v;
    run_prev = m_run;
    if (pll_lock) begin
      if (streak < 100000) streak++;
    end else begin
      streak = 0;
    end
    m_run = (streak >= LOCK_WAIT + 1);
    en_v  = '0;
    div_v = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (div_load[ch]) pend[ch] = int'(div_ratio[ch*DIV_W +: DIV_W]);
      if (m_run) begin
        if (!run_prev || (resync && run_prev) || cyc == s_cyc[ch] + len[ch]) begin
          s_cyc[ch] = cyc;
          len[ch]   = eff(pend[ch]);
        end
        en_v[ch]  = (cyc == s_cyc[ch]);
        div_v[ch] = ((cyc - s_cyc[ch]) < (len[ch] + 1) / 2);
      end
    end
    exp_q.push_back({m_run, en_v, div_v});
  endtask

  // Driver: one clock cycle, model update, then check away from the edge.
  task automatic tick();
    logic [W-1:0] want;
    @(posedge clkin);
    cyc++;
    model_step();
    #1;
    want = exp_q.pop_front();
    chk("outputs", {ready, clk_en, clk_div}, want);
  endtask

  task automatic wait_ready(output int at);
    at = -1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (ready) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_en0(output int at);
    at = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (clk_en[0]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic load_both(input int r0, input int r1);
    div_ratio[0 +: DIV_W]     = DIV_W'(r0);
    div_ratio[DIV_W +: DIV_W] = DIV_W'(r1);
    div_load = 2'b11;
    tick();
    div_load = 2'b00;
  endtask

  initial begin
    int rise_cyc, ready_cyc, e0, e1, e2, k, n_en0, n_div0, n_en1, n_div1;

    // Reset state.
    model_reset();
    #1 reset = 1'b1;
    #1 chk("reset_outputs", {ready, clk_en, clk_div}, '0);
    @(posedge clkin);
    #1 reset = 1'b0;
    cyc = 0;

    // Lock bring-up: lock rises in cycle 10, ready in cycle 75.
    repeat (10) tick();
    pll_lock = 1'b1;
    rise_cyc = cyc;
    chk("lock_rise_cycle", rise_cyc, 10);
    wait_ready(ready_cyc);
    chk("ready_cycle", ready_cyc, 75);
    chk("first_run_en", clk_en, 2'b11);
    chk("first_run_div", clk_div, 2'b11);

    // Odd ratio on ch0, ratio 0 on ch1.
    load_both(5, 0);
    repeat (12) tick();
    n_en0 = 0; n_div0 = 0; n_en1 = 0; n_div1 = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_en0  += int'(clk_en[0]);
      n_div0 += int'(clk_div[0]);
      n_en1  += int'(clk_en[1]);
      n_div1 += int'(clk_div[1]);
    end
    chk("r5_en_count", n_en0, 3);
    chk("r5_div_high", n_div0, 9);
    chk("r0_en_count", n_en1, 15);
    chk("r0_div_high", n_div1, 15);

    // Mid-period load: ratio 4 running, load 6 while cnt==1.
    div_ratio[0 +: DIV_W] = 8'd4;
    div_load = 2'b01;
    tick();
    div_load = 2'b00;
    repeat (12) tick();
    wait_en0(e0);
    tick();
    div_ratio[0 +: DIV_W] = 8'd6;
    div_load = 2'b01;
    tick();
    div_load = 2'b00;
    wait_en0(e1);
    wait_en0(e2);
    chk("midload_old_period", e1 - e0, 4);
    chk("midload_new_period", e2 - e1, 6);

    // Resync of ratio 3 / ratio 4 channels from an arbitrary phase.
    load_both(3, 4);
    k = $urandom_range(8, 19);
    repeat (k) tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("resync_aligned_en", clk_en, 2'b11);
    repeat (12) tick();

    // Lock loss in RUN, then relock.
    pll_lock = 1'b0;
    tick();
    chk("lockloss_outputs", {ready, clk_en, clk_div}, '0);
    tick();
    pll_lock = 1'b1;
    rise_cyc = cyc;
    wait_ready(ready_cyc);
    chk("relock_settle", ready_cyc - rise_cyc, LOCK_WAIT + 1);
    chk("relock_aligned_en", clk_en, 2'b11);

    // Randomized traffic.
    for (int i = 0; i < 1200; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        div_ratio[ch*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
        div_load[ch] = ($urandom_range(0, 7) == 0);
      end
      resync   = ($urandom_range(0, 15) == 0);
      pll_lock = ($urandom_range(0, 299) != 0);
      tick();
    end
    div_load = '0;
    resync   = 1'b0;
    pll_lock = 1'b1;
    wait_ready(ready_cyc);
    chk("random_recover_ready", ready, 1'b1);

    // Reset mid-RUN with non-default ratios loaded.
    load_both(7, 3);
    repeat (10) tick();
    @(posedge clkin);
    #3 reset = 1'b1;
    #1 chk("async_reset_outputs", {ready, clk_en, clk_div}, '0);
    model_reset();
    @(posedge clkin);
    #1 reset = 1'b0;
    cyc = 0;
    wait_ready(ready_cyc);
    chk("post_reset_ready", ready_cyc, LOCK_WAIT + 1);
    n_en0 = 0; n_en1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_en0 += int'(clk_en[0]);
      n_en1 += int'(clk_en[1]);
    end
    chk("post_reset_def_ch0", n_en0, 8 / DEF_DIV);
    chk("post_reset_def_ch1", n_en1, 8 / DEF_DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
